// File: rtl/mem_ctrl.sv
// mem_ctrl: line-granular main-memory responder with write/read arbitration and a fixed latency.
// Optional build macro MEM_CTRL_STATS_EN adds wrCount/rdCount completed-transaction counters.
module mem_ctrl #(
   parameter int unsigned ADDR_BITS   = 32,
   parameter int unsigned LINE_BITS   = 128,
   parameter int unsigned MEM_LINES   = 1024,
   parameter int unsigned MEM_LATENCY = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wMemReq,
   input  logic [ADDR_BITS-1:0] wAddrMem,
   input  logic [LINE_BITS-1:0] wDataMem,
   output logic                 wMemAck,
   input  logic                 rMemReq,
   input  logic [ADDR_BITS-1:0] rAddrMem,
   output logic [LINE_BITS-1:0] rDataMem,
`ifdef MEM_CTRL_STATS_EN
   output logic [31:0]          wrCount,
   output logic [31:0]          rdCount,
`endif
   output logic                 rMemValid
);

   localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);
   localparam int unsigned IDX_BITS = $clog2(MEM_LINES);
   localparam logic [7:0]  CNT_LOAD = 8'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t                r_state;
   logic [7:0]            r_cnt;
   logic                  r_lastWasWrite;
   logic                  r_opWrite;
   logic [IDX_BITS-1:0]   r_idx;
   logic [LINE_BITS-1:0]  r_wData;
   logic [LINE_BITS-1:0]  r_rData;
   logic                  r_wAck;
   logic                  r_rValid;
   logic [LINE_BITS-1:0]  r_mem [MEM_LINES];
`ifdef MEM_CTRL_STATS_EN
   logic [31:0]           r_wrCount;
   logic [31:0]           r_rdCount;
`endif

   logic                  w_anyReq;
   logic                  w_grantWrite;
   logic [IDX_BITS-1:0]   w_wIdx;
   logic [IDX_BITS-1:0]   w_rIdx;
   logic                  w_unused_addr;

   // Byte-offset bits below and aliasing bits above the line index are ignored.
   assign w_wIdx        = wAddrMem[OFF_BITS +: IDX_BITS];
   assign w_rIdx        = rAddrMem[OFF_BITS +: IDX_BITS];
   assign w_unused_addr = ^{wAddrMem, rAddrMem};

   assign w_anyReq     = wMemReq | rMemReq;
   assign w_grantWrite = wMemReq & (~rMemReq | ~r_lastWasWrite);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_lastWasWrite <= 1'b0;
         r_opWrite      <= 1'b0;
         r_idx          <= '0;
         r_wData        <= '0;
         r_rData        <= '0;
         r_wAck         <= 1'b0;
         r_rValid       <= 1'b0;
`ifdef MEM_CTRL_STATS_EN
         r_wrCount      <= '0;
         r_rdCount      <= '0;
`endif
      end else begin
         r_wAck   <= 1'b0;
         r_rValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_anyReq) begin
                  r_opWrite      <= w_grantWrite;
                  r_lastWasWrite <= w_grantWrite;
                  r_idx          <= w_grantWrite ? w_wIdx : w_rIdx;
                  if (w_grantWrite) begin
                     r_wData <= wDataMem;
                  end
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Response flags and read data are set on entry so they are registered during RESP.
               if (r_cnt == '0) begin
                  r_state <= S_RESP;
                  if (r_opWrite) begin
                     r_wAck <= 1'b1;
                  end else begin
                     r_rValid <= 1'b1;
                     r_rData  <= r_mem[r_idx];
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
`ifdef MEM_CTRL_STATS_EN
               if (r_opWrite) begin
                  r_wrCount <= r_wrCount + 32'd1;
               end else begin
                  r_rdCount <= r_rdCount + 32'd1;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Array commit happens at the end of RESP; a reset in that cycle aborts it.
   always_ff @(posedge clk) begin
      if (rst && (r_state == S_RESP) && r_opWrite) begin
         r_mem[r_idx] <= r_wData;
      end
   end

   assign wMemAck   = r_wAck;
   assign rMemValid = r_rValid;
   assign rDataMem  = r_rData;
`ifdef MEM_CTRL_STATS_EN
   assign wrCount   = r_wrCount;
   assign rdCount   = r_rdCount;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, directed corner sequences and a randomized run against a transaction-level model.
// Connects the wrCount/rdCount ports and checks them when MEM_CTRL_STATS_EN is defined.
module tb_mem_ctrl;

   localparam int AB  = 32;
   localparam int LB  = 128;
   localparam int ML  = 1024;
   localparam int LAT = 5;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          wMemReq  = 1'b0;
   logic          rMemReq  = 1'b0;
   logic [AB-1:0] wAddrMem = '0;
   logic [AB-1:0] rAddrMem = '0;
   logic [LB-1:0] wDataMem = '0;
   logic [LB-1:0] rDataMem;
   logic          wMemAck;
   logic          rMemValid;
`ifdef MEM_CTRL_STATS_EN
   logic [31:0]   wrCount;
   logic [31:0]   rdCount;
`endif

   int checks   = 0;
   int failures = 0;

   mem_ctrl #(
      .ADDR_BITS  (AB),
      .LINE_BITS  (LB),
      .MEM_LINES  (ML),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wMemReq  (wMemReq),
      .wAddrMem (wAddrMem),
      .wDataMem (wDataMem),
      .wMemAck  (wMemAck),
      .rMemReq  (rMemReq),
      .rAddrMem (rAddrMem),
      .rDataMem (rDataMem),
`ifdef MEM_CTRL_STATS_EN
      .wrCount  (wrCount),
      .rdCount  (rdCount),
`endif
      .rMemValid(rMemValid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit            is_w;
      logic [AB-1:0] addr;
      logic [LB-1:0] wdata;
      logic [LB-1:0] exp_rd;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      wMemReq = 1'b0;
      rMemReq = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // One transaction from an idle controller; lat is the cycle the pulse appears (-1 on timeout).
   task automatic do_txn(input bit is_w, input logic [AB-1:0] a, input logic [LB-1:0] d,
                         output int lat, output logic [LB-1:0] rd);
      lat = -1;
      rd  = '0;
      if (is_w) begin
         wMemReq = 1'b1; wAddrMem = a; wDataMem = d;
      end else begin
         rMemReq = 1'b1; rAddrMem = a;
      end
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         tick();
         if (is_w ? wMemAck : rMemValid) begin
            lat = c;
            rd  = rDataMem;
         end
      end
      wMemReq = 1'b0;
      rMemReq = 1'b0;
      tick();
      chk_bit("pulse_width_ack", wMemAck, 1'b0);
      chk_bit("pulse_width_valid", rMemValid, 1'b0);
   endtask

   function automatic logic [LB-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int idx_of(input logic [AB-1:0] a);
      return int'((a / 16) % ML);
   endfunction

   function automatic logic [AB-1:0] rand_addr(input int line);
      logic [AB-1:0] hi;
      hi = AB'($urandom_range(0, 262143));
      return hi * 16384 + AB'(line) * 16 + AB'($urandom_range(0, 15));
   endfunction

   localparam logic [LB-1:0] D_A = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [LB-1:0] D_B = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [LB-1:0] D_C = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [LB-1:0] D_Z = 128'hA5A5A5A55A5A5A5AA5A5A5A55A5A5A5A;
   localparam logic [LB-1:0] D_F = 128'hCAFEBABE_DEADBEEF_01020304_05060708;
   localparam logic [LB-1:0] D_G = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;

   vec_t          tbl [8];
   int            lat;
   logic [LB-1:0] rd;
   logic [LB-1:0] prev_rd;
   int            nacks;

   logic [LB-1:0] mdl_mem [16];
   int            free_at, resp_at, resp_slot;
   bit            resp_w, last_w, gw, e_ack, e_val;
   logic [LB-1:0] resp_data, exp_rd;

   initial begin
      tbl[0] = '{1'b1, 32'h0000_0040, D_A, '0};
      tbl[1] = '{1'b0, 32'h0000_004C, '0, D_A};
      tbl[2] = '{1'b1, 32'h0000_0000, D_Z, '0};
      tbl[3] = '{1'b1, 32'h0000_4000, D_B, '0};
      tbl[4] = '{1'b0, 32'h0000_0000, '0, D_B};
      tbl[5] = '{1'b1, 32'h0000_3FF0, D_C, '0};
      tbl[6] = '{1'b0, 32'h7FFF_FFFF, '0, D_C};
      tbl[7] = '{1'b0, 32'h0000_0004, '0, D_B};

      // Reset values while reset is held
      rst = 1'b0;
      tick();
      tick();
      chk_bit("reset_wack", wMemAck, 1'b0);
      chk_bit("reset_rvalid", rMemValid, 1'b0);
      chk("reset_rdata", rDataMem, '0);
      rst = 1'b1;

      prev_rd = '0;
      for (int i = 0; i < 8; i++) begin
         do_txn(tbl[i].is_w, tbl[i].addr, tbl[i].wdata, lat, rd);
         chk_int($sformatf("vec%0d_latency", i), lat, LAT + 1);
         if (tbl[i].is_w) begin
            chk($sformatf("vec%0d_rdata_hold", i), rd, prev_rd);
         end else begin
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            prev_rd = tbl[i].exp_rd;
         end
      end

      // Reset during BUSY: no ack, line 0 keeps D_B
      wMemReq = 1'b1; wAddrMem = 32'h0; wDataMem = D_F;
      tick(); tick(); tick();
      rst = 1'b0; wMemReq = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_busy_rdata_reset", rDataMem, '0);
      for (int c = 0; c < 10; c++) begin
         chk_bit("abort_busy_no_ack", wMemAck, 1'b0);
         tick();
      end
      do_txn(1'b0, 32'h0, '0, lat, rd);
      chk("abort_busy_line_kept", rd, D_B);

      // Reset during RESP: the ack was shown but the array must not change
      wMemReq = 1'b1; wAddrMem = 32'h8; wDataMem = D_G;
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         tick();
         if (wMemAck) lat = c;
      end
      chk_int("abort_resp_ack_cycle", lat, LAT + 1);
      rst = 1'b0; wMemReq = 1'b0;
      tick();
      rst = 1'b1;
      chk_bit("abort_resp_ack_cleared", wMemAck, 1'b0);
      do_txn(1'b0, 32'h0, '0, lat, rd);
      chk("abort_resp_line_kept", rd, D_B);

      // Simultaneous requests after reset: write first, then round-robin
      do_reset();
      wMemReq = 1'b1; wAddrMem = 32'h100; wDataMem = D_F;
      rMemReq = 1'b1; rAddrMem = 32'h3FF0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         chk_bit("tie_wack", wMemAck, (c == 6 || c == 20));
         chk_bit("tie_rvalid", rMemValid, (c == 13 || c == 27));
         if (c == 6 || c == 20) wMemReq = 1'b0;
         if (c == 13) begin
            chk("tie_rdata1", rDataMem, D_C);
            wMemReq = 1'b1; wAddrMem = 32'h110; wDataMem = ~D_F;
            rAddrMem = 32'h108;
         end
         if (c == 27) begin
            chk("tie_rdata2", rDataMem, D_F);
            rMemReq = 1'b0;
         end
      end

      // Held write request for 20 cycles: one ack per 7-cycle transaction
      wMemReq = 1'b1; wAddrMem = 32'h200; wDataMem = D_G;
      nacks = 0;
      for (int c = 1; c <= 26; c++) begin
         tick();
         chk_bit("held_wack", wMemAck, (c % 7 == 6) && (c <= 20));
         if (wMemAck) nacks++;
         if (c == 20) wMemReq = 1'b0;
      end
      chk_int("held_ack_count", nacks, 3);

`ifdef MEM_CTRL_STATS_EN
      do_reset();
      chk("stats_reset_wr", LB'(wrCount), '0);
      chk("stats_reset_rd", LB'(rdCount), '0);
      for (int i = 0; i < 3; i++) do_txn(1'b1, AB'(32'h300 + i * 16), rand_line(), lat, rd);
      for (int i = 0; i < 2; i++) do_txn(1'b0, AB'(32'h300 + i * 16), '0, lat, rd);
      chk_int("stats_wr", int'(wrCount), 3);
      chk_int("stats_rd", int'(rdCount), 2);
      do_reset();
      chk_int("stats_wr_after_reset", int'(wrCount), 0);
      chk_int("stats_rd_after_reset", int'(rdCount), 0);
`endif

      // Randomized traffic on lines 32..47 against a transaction-level model
      for (int k = 0; k < 16; k++) begin
         mdl_mem[k] = rand_line();
         do_txn(1'b1, rand_addr(32 + k), mdl_mem[k], lat, rd);
      end
      do_reset();
      free_at = 0; resp_at = -1; last_w = 1'b0; exp_rd = '0;
      resp_w = 1'b0; resp_slot = 0; resp_data = '0;
      for (int t = 0; t < 1200; t++) begin
         e_ack = (t == resp_at) && resp_w;
         e_val = (t == resp_at) && !resp_w;
         if (e_val) exp_rd = mdl_mem[resp_slot];
         chk_bit("rand_wack", wMemAck, e_ack);
         chk_bit("rand_rvalid", rMemValid, e_val);
         chk("rand_rdata", rDataMem, exp_rd);
         if (e_ack) begin
            mdl_mem[resp_slot] = resp_data;
            wMemReq = 1'b0;
         end
         if (e_val) rMemReq = 1'b0;
         if (!wMemReq && $urandom_range(0, 2) == 0) begin
            wMemReq = 1'b1; wAddrMem = rand_addr(32 + $urandom_range(0, 15)); wDataMem = rand_line();
         end
         if (!rMemReq && $urandom_range(0, 2) == 0) begin
            rMemReq = 1'b1; rAddrMem = rand_addr(32 + $urandom_range(0, 15));
         end
         if (t >= free_at && (wMemReq || rMemReq)) begin
            gw        = wMemReq && (!rMemReq || !last_w);
            last_w    = gw;
            resp_w    = gw;
            resp_slot = idx_of(gw ? wAddrMem : rAddrMem) - 32;
            resp_data = wDataMem;
            resp_at   = t + LAT + 1;
            free_at   = t + LAT + 2;
         end
         tick();
      end
      wMemReq = 1'b0;
      rMemReq = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
